stopwatch_counter: RTL and testbench

Downstream consumer of the stopwatch control FSM's one-hot state. It divides the system clock to a 100 Hz tick and keeps a BCD time count in MM:SS.hh form: minutes, seconds, hundredths. Its digit outputs feed the display/segment driver stage. The count advances in RUNNING, holds in IDLE, and is forced to zero in CLEAR.

---
 rtl/stopwatch_pkg.sv | 26 ++
 rtl/stopwatch_counter_digit.sv | 41 ++++
 rtl/stopwatch_counter.sv | 101 ++++++++++
 tb/tb_stopwatch_counter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: FSM state encodings, BCD digit type,
// digit limits and the digit-position helper used by the counter.
package stopwatch_pkg;

    // One-hot states driven by the stopwatch control FSM.
    typedef enum logic [2:0] {
        IDLE    = 3'b100,
        CLEAR   = 3'b010,
        RUNNING = 3'b001
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam bcd_t DIGIT_MAX_9 = 4'd9;
    localparam bcd_t DIGIT_MAX_5 = 4'd5;

    // Digit positions, least significant first: hs_ones, hs_tens, s_ones,
    // s_tens, m_ones, m_tens.
    localparam int NUM_DIGITS = 6;

    // Tens-of-seconds and tens-of-minutes roll over at 5; every other digit at 9.
    function automatic bcd_t digit_max(input int idx);
        return ((idx == 3) || (idx == 5)) ? DIGIT_MAX_5 : DIGIT_MAX_9;
    endfunction

endpackage

// File: rtl/stopwatch_counter_digit.sv
// Single BCD digit with synchronous clear and carry-in. The carry-out is
// combinational so a whole chain of digits resolves on one edge.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = DIGIT_MAX_9
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output bcd_t q,
    output logic co
);

    bcd_t q_reg;
    bcd_t q_next;

    // Next digit value: clear wins, otherwise step with rollover at MAX.
    always_comb begin
        q_next = q_reg;
        if (clr) begin
            q_next = '0;
        end else if (en) begin
            q_next = (q_reg == MAX) ? bcd_t'(0) : bcd_t'(q_reg + 4'd1);
        end
    end

    // Digit register with active-low synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q  = q_reg;
    assign co = en && (q_reg == MAX);

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch time base: divides clk down to a TICK_HZ tick and keeps an
// MM:SS.hh BCD count that runs, holds or clears according to the FSM state.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 10_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] state,
    output logic [3:0] hs_ones,
    output logic [3:0] hs_tens,
    output logic [3:0] s_ones,
    output logic [3:0] s_tens,
    output logic [3:0] m_ones,
    output logic [3:0] m_tens,
    output logic       tick,
    output logic       wrap
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

    logic          run_cmd;
    logic          clr_cmd;
    logic [PW-1:0] ps_reg;
    logic [PW-1:0] ps_next;
    logic          tick_reg;
    logic          tick_next;
    logic          wrap_reg;
    logic          wrap_next;

    // carry[0] is the tick into hs_ones; carry[NUM_DIGITS] is the full wrap.
    logic [NUM_DIGITS:0] carry;
    bcd_t                digit_q [NUM_DIGITS];

    // Decode the state; anything that is not exactly RUNNING or CLEAR holds.
    always_comb begin
        run_cmd = (state == RUNNING);
        clr_cmd = (state == CLEAR);
    end

    // Prescaler next value and the tick/wrap that land on the same edge.
    always_comb begin
        ps_next   = ps_reg;
        tick_next = 1'b0;
        if (clr_cmd) begin
            ps_next = '0;
        end else if (run_cmd) begin
            if (ps_reg == PS_LAST) begin
                ps_next   = '0;
                tick_next = 1'b1;
            end else begin
                ps_next = ps_reg + PW'(1);
            end
        end
        wrap_next = carry[NUM_DIGITS];
    end

    // Prescaler and output pulse registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ps_reg   <= '0;
            tick_reg <= 1'b0;
            wrap_reg <= 1'b0;
        end else begin
            ps_reg   <= ps_next;
            tick_reg <= tick_next;
            wrap_reg <= wrap_next;
        end
    end

    assign carry[0] = tick_next;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            bcd_digit #(
                .MAX(digit_max(gi))
            ) u_digit (
                .clk(clk),
                .rst(rst),
                .clr(clr_cmd),
                .en (carry[gi]),
                .q  (digit_q[gi]),
                .co (carry[gi+1])
            );
        end
    endgenerate

    assign hs_ones = digit_q[0];
    assign hs_tens = digit_q[1];
    assign s_ones  = digit_q[2];
    assign s_tens  = digit_q[3];
    assign m_ones  = digit_q[4];
    assign m_tens  = digit_q[5];
    assign tick    = tick_reg;
    assign wrap    = wrap_reg;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with CLK_HZ=400, TICK_HZ=100 (DIV=4).
// Digits are compared as a packed 24-bit BCD word m_tens..hs_ones, so
// 00:03.47 reads as 24'h000347. The rollover cases preset the digit registers
// with force so the carry chain can be exercised without a full hour of ticks.
module tb_stopwatch_counter;

    logic       clk;
    logic       rst;
    logic [2:0] state;
    logic [3:0] hs_ones, hs_tens, s_ones, s_tens, m_ones, m_tens;
    logic       tick;
    logic       wrap;
    logic [23:0] digits;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] ST_IDLE    = 3'b100;
    localparam logic [2:0] ST_CLEAR   = 3'b010;
    localparam logic [2:0] ST_RUNNING = 3'b001;

    stopwatch_counter #(
        .CLK_HZ (400),
        .TICK_HZ(100)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .state  (state),
        .hs_ones(hs_ones),
        .hs_tens(hs_tens),
        .s_ones (s_ones),
        .s_tens (s_tens),
        .m_ones (m_ones),
        .m_tens (m_tens),
        .tick   (tick),
        .wrap   (wrap)
    );

    assign digits = {m_tens, m_ones, s_tens, s_ones, hs_tens, hs_ones};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Advance n clock edges; returns at a negedge so outputs are stable.
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cycles(1);
        rst = 1'b1;
    endtask

    initial begin
        rst   = 1'b0;
        state = ST_RUNNING;
        @(negedge clk);

        // 1. Reset held with RUNNING, then first tick after DIV cycles.
        cycles(2);
        check("reset_digits", 32'(digits), 32'h000000);
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_wrap", 32'(wrap), 32'd0);
        rst = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cycles(1);
            check($sformatf("first_tick_c%0d", i), 32'(tick), (i == 4) ? 32'd1 : 32'd0);
        end
        check("first_advance", 32'(digits), 32'h000001);
        cycles(1);
        check("tick_single_cycle", 32'(tick), 32'd0);

        // 2. Carries into hs_tens and into s_ones.
        cycles(35);
        check("carry_hs_tens", 32'(digits), 32'h000010);
        cycles(360);
        check("carry_s_ones", 32'(digits), 32'h000100);
        check("carry_s_ones_tick", 32'(tick), 32'd1);
        check("carry_s_ones_wrap", 32'(wrap), 32'd0);

        // 3. Pause mid-period and resume without losing the partial period.
        do_reset();
        cycles(6);
        check("pause_pre", 32'(digits), 32'h000001);
        state = ST_IDLE;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            check("pause_hold", 32'(digits), 32'h000001);
            check("pause_tick", 32'(tick), 32'd0);
        end
        state = ST_RUNNING;
        cycles(1);
        check("resume_c1_digits", 32'(digits), 32'h000001);
        check("resume_c1_tick", 32'(tick), 32'd0);
        cycles(1);
        check("resume_c2_digits", 32'(digits), 32'h000002);
        check("resume_c2_tick", 32'(tick), 32'd1);

        // 4. Clear from 00:03.47, held for 20 more cycles, then restart.
        do_reset();
        cycles(347 * 4);
        check("clear_pre", 32'(digits), 32'h000347);
        state = ST_CLEAR;
        cycles(1);
        check("clear_first_edge", 32'(digits), 32'h000000);
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            check("clear_hold", 32'(digits), 32'h000000);
            check("clear_tick", 32'(tick), 32'd0);
        end
        state = ST_RUNNING;
        for (int i = 1; i <= 4; i++) begin
            cycles(1);
            check($sformatf("post_clear_c%0d", i), 32'(digits), (i == 4) ? 32'h000001 : 32'h000000);
        end
        check("post_clear_tick", 32'(tick), 32'd1);

        // 6a. Non-one-hot state values hold the count and the prescaler.
        cycles(2);
        state = 3'b011;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            check("state_011_hold", 32'(digits), 32'h000001);
            check("state_011_tick", 32'(tick), 32'd0);
        end
        begin
            logic [2:0] bad_states [4];
            bad_states = '{3'b000, 3'b101, 3'b110, 3'b111};
            for (int k = 0; k < 4; k++) begin
                state = bad_states[k];
                cycles(3);
                check($sformatf("state_%b_hold", bad_states[k]), 32'(digits), 32'h000001);
            end
        end
        state = ST_RUNNING;
        cycles(1);
        check("resume_after_bad_c1", 32'(digits), 32'h000001);
        cycles(1);
        check("resume_after_bad_c2", 32'(digits), 32'h000002);

        // 6b. Reset mid-period at 00:01.23 restarts with a full DIV period.
        do_reset();
        cycles(123 * 4);
        check("midrst_pre", 32'(digits), 32'h000123);
        cycles(2);
        rst = 1'b0;
        cycles(1);
        check("midrst_digits", 32'(digits), 32'h000000);
        check("midrst_tick", 32'(tick), 32'd0);
        rst = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cycles(1);
            check($sformatf("midrst_restart_c%0d", i), 32'(digits), (i == 4) ? 32'h000001 : 32'h000000);
        end

        // Minute carry: 00:59.99 -> 01:00.00 without wrap.
        do_reset();
        state = ST_IDLE;
        force dut.g_digit[0].u_digit.q_reg = 4'd9;
        force dut.g_digit[1].u_digit.q_reg = 4'd9;
        force dut.g_digit[2].u_digit.q_reg = 4'd9;
        force dut.g_digit[3].u_digit.q_reg = 4'd5;
        cycles(1);
        release dut.g_digit[0].u_digit.q_reg;
        release dut.g_digit[1].u_digit.q_reg;
        release dut.g_digit[2].u_digit.q_reg;
        release dut.g_digit[3].u_digit.q_reg;
        cycles(1);
        check("minute_preset", 32'(digits), 32'h005999);
        state = ST_RUNNING;
        cycles(4);
        check("minute_carry", 32'(digits), 32'h010000);
        check("minute_tick", 32'(tick), 32'd1);
        check("minute_wrap", 32'(wrap), 32'd0);

        // 5. Full wrap: 59:59.99 -> 00:00.00 with wrap and tick for one cycle.
        do_reset();
        state = ST_IDLE;
        force dut.g_digit[0].u_digit.q_reg = 4'd9;
        force dut.g_digit[1].u_digit.q_reg = 4'd9;
        force dut.g_digit[2].u_digit.q_reg = 4'd9;
        force dut.g_digit[3].u_digit.q_reg = 4'd5;
        force dut.g_digit[4].u_digit.q_reg = 4'd9;
        force dut.g_digit[5].u_digit.q_reg = 4'd5;
        cycles(1);
        release dut.g_digit[0].u_digit.q_reg;
        release dut.g_digit[1].u_digit.q_reg;
        release dut.g_digit[2].u_digit.q_reg;
        release dut.g_digit[3].u_digit.q_reg;
        release dut.g_digit[4].u_digit.q_reg;
        release dut.g_digit[5].u_digit.q_reg;
        cycles(1);
        check("wrap_preset", 32'(digits), 32'h595999);
        state = ST_RUNNING;
        for (int i = 1; i <= 4; i++) begin
            cycles(1);
            check($sformatf("wrap_c%0d_digits", i), 32'(digits), (i == 4) ? 32'h000000 : 32'h595999);
            check($sformatf("wrap_c%0d_wrap", i), 32'(wrap), (i == 4) ? 32'd1 : 32'd0);
            check($sformatf("wrap_c%0d_tick", i), 32'(tick), (i == 4) ? 32'd1 : 32'd0);
        end
        cycles(1);
        check("wrap_drop", 32'(wrap), 32'd0);
        check("wrap_tick_drop", 32'(tick), 32'd0);
        check("wrap_after_digits", 32'(digits), 32'h000000);
        cycles(3);
        check("wrap_next_count", 32'(digits), 32'h000001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
